sdram_sim: RTL and testbench

SDRAM_SIM -- requirements
Module: sdram_sim

---
 rtl/sdram_sim_if.sv | 20 ++
 rtl/sdram_sim.sv | 61 ++++++
 tb/tb_sdram_sim.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/sdram_sim_if.sv
// sdram_sim_if: request/response bus between a requester and the sdram_sim model.
interface sdram_sim_if;
   logic [31:0] w_addr;
   logic        w_le;
   logic        w_we;
   logic [31:0] w_wdata;
   logic [3:0]  w_mask;
   logic        w_refresh;
   logic [31:0] w_mtime;
   logic [31:0] w_odata;
   logic        w_stall;
   modport master (
      output w_addr, w_le, w_we, w_wdata, w_mask, w_refresh, w_mtime,
      input  w_odata, w_stall
   );
   modport slave (
      input  w_addr, w_le, w_we, w_wdata, w_mask, w_refresh, w_mtime,
      output w_odata, w_stall
   );
endinterface

// File: rtl/sdram_sim.sv
// sdram_sim: byte-array SDRAM model with fixed access/refresh busy latency.
// Define SDRAM_SIM_REFRESH_EN to honour w_refresh; otherwise it is ignored.
module sdram_sim #(
   parameter int MEM_SIZE = 67108864,
   parameter int ACC_LAT  = 4,
   parameter int REF_LAT  = 8
) (
   input logic        clk,
   input logic        rst_x,
   sdram_sim_if.slave bus
);
   localparam int AW = $clog2(MEM_SIZE);
   typedef enum logic {IDLE, BUSY} state_t;
   typedef enum logic [1:0] {OP_RD, OP_WR, OP_RF} op_t;
   logic [7:0] mem [0:MEM_SIZE-1];
   state_t state, next_state;
   op_t op, sel_op;
   logic [AW-1:0] idx, req_idx;
   logic [15:0] cnt;
   logic [31:0] odata, rd_word;
   logic refresh, accept, done;
`ifdef SDRAM_SIM_REFRESH_EN
   assign refresh = bus.w_refresh;
`else
   assign refresh = 1'b0;
`endif
   // Higher address bits alias naturally by truncation to AW bits.
   assign req_idx = {bus.w_addr[AW-1:2], 2'b00};
   always_comb begin
      sel_op = refresh ? OP_RF : bus.w_we ? OP_WR : OP_RD;
      accept = state == IDLE && (refresh || bus.w_we || bus.w_le);
      done = state == BUSY && cnt == 16'd1;
      next_state = accept ? BUSY : done ? IDLE : state;
      rd_word = {mem[{idx[AW-1:2], 2'd3}], mem[{idx[AW-1:2], 2'd2}],
                 mem[{idx[AW-1:2], 2'd1}], mem[{idx[AW-1:2], 2'd0}]};
   end
   always_ff @(posedge clk or negedge rst_x)
      if (!rst_x) state <= IDLE;
      else state <= next_state;
   always_ff @(posedge clk or negedge rst_x)
      if (!rst_x) begin
         op <= OP_RD;
         idx <= '0;
         cnt <= '0;
         odata <= '0;
      end else begin
         if (accept) begin
            op <= sel_op;
            idx <= req_idx;
            cnt <= sel_op == OP_RF ? 16'(REF_LAT) : 16'(ACC_LAT);
         end else if (state == BUSY) cnt <= cnt - 16'd1;
         if (done && op == OP_RD) odata <= rd_word;
      end
   // Writes commit on the accept edge; memory is deliberately outside reset.
   always_ff @(posedge clk)
      if (rst_x && accept && sel_op == OP_WR)
         for (int i = 0; i < 4; i++)
            if (bus.w_mask[i]) mem[{req_idx[AW-1:2], 2'(i)}] <= bus.w_wdata[8*i +: 8];
   assign bus.w_stall = state == BUSY;
   assign bus.w_odata = odata;
endmodule

// File: tb/tb_sdram_sim.sv
// tb_sdram_sim: randomized bench for sdram_sim against a byte-array reference model.
module tb_sdram_sim;
   localparam int MS = 65536;
   localparam int AL = 4;
   localparam int RL = 8;
   logic clk = 1'b0;
   logic rst_x = 1'b0;
   always #5 clk = ~clk;
   sdram_sim_if bus();
   sdram_sim #(.MEM_SIZE(MS), .ACC_LAT(AL), .REF_LAT(RL)) dut (.clk(clk), .rst_x(rst_x), .bus(bus));
   logic [7:0] model [0:MS-1];
   logic [31:0] exp_od;
   int checks = 0;
   int failures = 0;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask
   function automatic int widx(input logic [31:0] a);
      return int'(a & 32'(MS - 1)) & ~3;
   endfunction
   function automatic logic [31:0] mword(input logic [31:0] a);
      int b = widx(a);
      return {model[b+3], model[b+2], model[b+1], model[b]};
   endfunction
   // kind: 0 read, 1 write, 2 refresh; rf_too raises w_refresh alongside.
   task automatic op(input int kind, input logic [31:0] a, input logic [31:0] d, input logic [3:0] m, input bit rf_too);
      int n, eff, b;
`ifdef SDRAM_SIM_REFRESH_EN
      eff = (kind == 2 || rf_too) ? 2 : kind;
`else
      eff = kind;
`endif
      @(negedge clk);
      bus.w_addr = a;
      bus.w_wdata = d;
      bus.w_mask = m;
      bus.w_le = kind == 0;
      bus.w_we = kind == 1;
      bus.w_refresh = kind == 2 || rf_too;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.w_stall && n < 20);
      bus.w_le = 0;
      bus.w_we = 0;
      bus.w_refresh = 0;
      if (!bus.w_stall) begin
         check("accept", 32'(bus.w_stall), 32'd1);
         return;
      end
      n = 1;
      forever begin
         @(negedge clk);
         if (!bus.w_stall || n >= 50) break;
         n++;
      end
      check("latency", n, eff == 2 ? RL : AL);
      if (eff == 1) begin
         b = widx(a);
         for (int i = 0; i < 4; i++) if (m[i]) model[b+i] = d[8*i +: 8];
      end else if (eff == 0) exp_od = mword(a);
      check("odata", bus.w_odata, exp_od);
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1, "timeout");
   end
   initial begin
      int rises, gap, n, stuck;
      logic prev;
      logic [7:0] r;
      bus.w_addr = 0;
      bus.w_le = 0;
      bus.w_we = 0;
      bus.w_wdata = 0;
      bus.w_mask = 0;
      bus.w_refresh = 0;
      bus.w_mtime = 0;
      for (int i = 0; i < MS; i++) begin
         r = 8'($urandom);
         model[i] = r;
         dut.mem[i] = r;
      end
      exp_od = 0;
      repeat (3) @(negedge clk);
      check("rst_stall", 32'(bus.w_stall), 32'd0);
      check("rst_odata", bus.w_odata, 32'd0);
      rst_x = 1;
      op(0, 32'h200, 0, 0, 0);
      op(1, 32'h100, 32'h11223344, 4'b1111, 0);
      op(0, 32'h100, 0, 0, 0);
      check("full_word", bus.w_odata, 32'h11223344);
      op(1, 32'h100, 32'hAABBCCDD, 4'b0110, 0);
      op(0, 32'h100, 0, 0, 0);
      check("mask_0110", bus.w_odata, 32'h11BBCC44);
      op(1, 32'h100, 32'hFFFFFFFF, 4'b0000, 0);
      op(0, 32'h103, 0, 0, 0);
      check("mask_none", bus.w_odata, 32'h11BBCC44);
      op(0, 32'h300, 0, 0, 0);
      op(0, 32'(MS) + 32'h100, 0, 0, 0);
      check("alias", bus.w_odata, 32'h11BBCC44);
      op(0, 32'h200, 0, 0, 1);
`ifdef SDRAM_SIM_REFRESH_EN
      check("rf_wins", bus.w_odata, 32'h11BBCC44);
      op(2, 0, 0, 0, 0);
`else
      check("rf_ignored", bus.w_odata, mword(32'h200));
`endif
      @(negedge clk);
      bus.w_addr = 32'h100;
      bus.w_le = 1;
      rises = 0;
      gap = 0;
      n = 0;
      prev = 0;
      while (rises < 2 && n < 40) begin
         @(negedge clk);
         n++;
         if (bus.w_stall && !prev) rises++;
         if (!bus.w_stall && rises == 1) gap++;
         prev = bus.w_stall;
      end
      bus.w_le = 0;
      check("b2b_rises", rises, 2);
      check("b2b_gap", gap, 1);
      n = 0;
      while (bus.w_stall && n < 20) begin
         @(negedge clk);
         n++;
      end
      exp_od = mword(32'h100);
      check("b2b_odata", bus.w_odata, exp_od);
      op(0, 32'h204, 0, 0, 0);
      stuck = 0;
      repeat (6) begin
         @(negedge clk);
         if (bus.w_stall) stuck++;
      end
      check("single_read", stuck, 0);
      @(negedge clk);
      bus.w_addr = 32'h100;
      bus.w_le = 1;
      @(negedge clk);
      bus.w_le = 0;
      @(negedge clk);
      rst_x = 0;
      #1;
      check("abort_stall", 32'(bus.w_stall), 32'd0);
      check("abort_odata", bus.w_odata, 32'd0);
      exp_od = 0;
      @(negedge clk);
      rst_x = 1;
      op(0, 32'h100, 0, 0, 0);
      check("kept_mem", bus.w_odata, 32'h11BBCC44);
      for (int k = 0; k < 80; k++) begin
`ifdef SDRAM_SIM_REFRESH_EN
         op($urandom_range(0, 2), $urandom, $urandom, 4'($urandom), $urandom_range(0, 3) == 0);
`else
         op($urandom_range(0, 1), $urandom, $urandom, 4'($urandom), $urandom_range(0, 3) == 0);
`endif
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
